// File: rtl/newhope_pkg.sv
// Shared constants and FSM state encoding for the NewHope polynomial
// serialization blocks.
package newhope_pkg;

    localparam int N          = 512;
    localparam int Q          = 12289;
    localparam int Q5         = 61445;
    localparam int COEFF_BITS = 14;
    localparam int OUT_WORDS  = 224;
    localparam int BUF_W      = 46;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/poly_freeze.sv
// Combinational 16-bit to 14-bit coefficient reduction mod Q.
// With POLY_FREEZE_EN defined it fully reduces 0..65535; otherwise it truncates.
module poly_freeze
    import newhope_pkg::*;
(
    input  logic [15:0] a_i,
    output logic [13:0] c_o
);

`ifdef POLY_FREEZE_EN
    localparam logic [15:0] Q_1 = 16'(Q);
    localparam logic [15:0] Q_2 = 16'(2 * Q);
    localparam logic [15:0] Q_3 = 16'(3 * Q);
    localparam logic [15:0] Q_4 = 16'(4 * Q);
    localparam logic [15:0] Q_5 = 16'(Q5);

    logic [4:0]  ge;
    logic [15:0] diff;

    // All five compares run in parallel; the highest passing multiple wins.
    always_comb begin
        ge[0] = (a_i >= Q_1);
        ge[1] = (a_i >= Q_2);
        ge[2] = (a_i >= Q_3);
        ge[3] = (a_i >= Q_4);
        ge[4] = (a_i >= Q_5);
        if (ge[4])      diff = a_i - Q_5;
        else if (ge[3]) diff = a_i - Q_4;
        else if (ge[2]) diff = a_i - Q_3;
        else if (ge[1]) diff = a_i - Q_2;
        else if (ge[0]) diff = a_i - Q_1;
        else            diff = a_i;
    end

    assign c_o = diff[13:0];

    logic unused_diff_hi;
    assign unused_diff_hi = ^diff[15:14];
`else
    assign c_o = a_i[13:0];

    logic unused_a_hi;
    assign unused_a_hi = ^a_i[15:14];
`endif

endmodule

// File: rtl/poly_tobytes.sv
// Packs 512 poly-RAM coefficients as 14-bit LSB-first fields into 224 byte-RAM words.
// Optional full mod-Q reduction of each coefficient: define POLY_FREEZE_EN.
module poly_tobytes
    import newhope_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [8:0]  poly_addr,
    input  logic [15:0] poly_do,
    output logic        byte_wea,
    output logic [7:0]  byte_addr,
    output logic [31:0] byte_dia
);

    state_t state_q, state_d;

    logic [8:0]       addr_q;
    logic             vld_p0;
    logic             vld_p1_q;
    logic             vld_p2_q;
    logic [13:0]      c_p1;
    logic [13:0]      c_p2_q;

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [5:0]       fill_q, fill_d;
    logic [BUF_W-1:0] app;
    logic [5:0]       fill_sum;
    logic             emit;
    logic [7:0]       word_q;

    logic             wea_q;
    logic [7:0]       waddr_q;
    logic [31:0]      wdata_q;

    logic             go;
    assign go = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (addr_q == 9'(N - 1)) state_d = ST_DRAIN;
            ST_DRAIN: if (!vld_p1_q && !vld_p2_q) state_d = ST_FIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vld_p0 = (state_q == ST_READ);
        done   = (state_q == ST_FIN);
    end

    // Stage 0: address out
    always_ff @(posedge clk) begin
        if (rst)         addr_q <= '0;
        else if (go)     addr_q <= '0;
        else if (vld_p0) addr_q <= addr_q + 9'd1;
    end

    // Stage 1: RAM data valid, reduce to 14 bits
    poly_freeze u_freeze (
        .a_i (poly_do),
        .c_o (c_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p0;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        c_p2_q <= c_p1;
    end

    // Stage 2: append above the fill level; a full low word leaves the same cycle
    always_comb begin
        app      = buf_q | ({{(BUF_W - 14){1'b0}}, c_p2_q} << fill_q);
        fill_sum = fill_q + 6'd14;
        emit     = vld_p2_q && (fill_sum >= 6'd32);
        buf_d    = buf_q;
        fill_d   = fill_q;
        if (vld_p2_q) begin
            if (emit) begin
                buf_d  = app >> 32;
                fill_d = fill_sum - 6'd32;
            end else begin
                buf_d  = app;
                fill_d = fill_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            wea_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            wea_q  <= emit;
            if (emit) begin
                // Stream byte 4w lands in [31:24]
                wdata_q <= {app[7:0], app[15:8], app[23:16], app[31:24]};
                waddr_q <= word_q;
                word_q  <= word_q + 8'd1;
            end
            if (go) word_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_FIN) begin
            assert (fill_q == 6'd0 && buf_q == '0);
        end
    end

    assign poly_addr = addr_q;
    assign byte_wea  = wea_q;
    assign byte_addr = waddr_q;
    assign byte_dia  = wdata_q;

endmodule

// File: tb/tb_poly_tobytes.sv
// Directed bench for poly_tobytes: RAM model, write capture and a bit-level packing model.
module tb_poly_tobytes;

    localparam int Q = 12289;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [8:0]  poly_addr;
    logic [15:0] poly_do;
    logic        byte_wea;
    logic [7:0]  byte_addr;
    logic [31:0] byte_dia;

    always #5 clk = ~clk;

    poly_tobytes dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .poly_addr (poly_addr),
        .poly_do   (poly_do),
        .byte_wea  (byte_wea),
        .byte_addr (byte_addr),
        .byte_dia  (byte_dia)
    );

    logic [15:0] mem [512];
    logic [31:0] cap [224];

    always @(posedge clk) poly_do <= mem[poly_addr];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt, done_cnt, addr_bad, done_bad;
    logic prev_wea;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                if (!prev_wea || wr_cnt != 224) done_bad++;
            end
            if (byte_wea) begin
                if (byte_addr != 8'(wr_cnt)) addr_bad++;
                if (wr_cnt < 224) cap[wr_cnt] = byte_dia;
                wr_cnt++;
            end
            prev_wea = byte_wea;
        end
    end

    function automatic logic [13:0] red(input logic [15:0] v);
`ifdef POLY_FREEZE_EN
        return 14'(int'(v) % Q);
`else
        return v[13:0];
`endif
    endfunction

    // Stream bit s is bit s%14 of coefficient s/14; byte 4w+k sits at [31-8k -: 8].
    function automatic logic [31:0] gold(input int w);
        logic [31:0] r;
        logic [13:0] cv;
        int s, k;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            s  = 32 * w + j;
            cv = red(mem[s / 14]);
            k  = (s / 8) - 4 * w;
            r[(3 - k) * 8 + (s % 8)] = cv[s % 14];
        end
        return r;
    endfunction

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    task automatic fill_rand(input int maxv);
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(maxv, 0));
    endtask

    task automatic run(input string tag, input int repulse, input int rst_at, input bit full);
        int lat;
        int snap;
        lat = 0;
        snap = 0;
        wr_cnt = 0; done_cnt = 0; addr_bad = 0; done_bad = 0;
        prev_wea = 1'b0;
        mon_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 560; c++) begin
            @(negedge clk);
            if (done && lat == 0) lat = c;
            start = (c == repulse);
            if (c == rst_at) rst = 1'b1;
            else if (c == rst_at + 1) begin
                rst  = 1'b0;
                snap = wr_cnt;
            end
        end
        mon_en = 1'b0;
        if (full) begin
            chk({tag, ".writes"},   32'(wr_cnt),   32'd224);
            chk({tag, ".dones"},    32'(done_cnt), 32'd1);
            chk({tag, ".addr_seq"}, 32'(addr_bad), 32'd0);
            chk({tag, ".done_pos"}, 32'(done_bad), 32'd0);
            chk({tag, ".latency"}, (lat >= 512 && lat <= 518) ? 32'd515 : 32'(lat), 32'd515);
            for (int w = 0; w < 224; w++)
                chk($sformatf("%s.w%0d", tag, w), cap[w], gold(w));
        end else begin
            chk({tag, ".was_writing"}, 32'(snap != 0), 32'd1);
            chk({tag, ".writes_after_rst"}, 32'(wr_cnt), 32'(snap));
            chk({tag, ".dones"}, 32'(done_cnt), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fill_const(16'd0);
        repeat (3) @(negedge clk);
        chk("rst.done",      32'(done),      32'd0);
        chk("rst.byte_wea",  32'(byte_wea),  32'd0);
        chk("rst.byte_addr", 32'(byte_addr), 32'd0);
        chk("rst.byte_dia",  byte_dia,       32'd0);
        chk("rst.poly_addr", 32'(poly_addr), 32'd0);
        rst = 1'b0;

        // Reset and start together: reset must win
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk);
        chk("rst_start.poly_addr", 32'(poly_addr), 32'd0);
        chk("rst_start.byte_wea",  32'(byte_wea),  32'd0);

        fill_const(16'd0);
        run("zero", -1, -1, 1'b1);
        chk("zero.w0_hand", cap[0], 32'h0000_0000);

        fill_const(16'd1);
        run("ones", -1, -1, 1'b1);
        chk("ones.w0_hand", cap[0], 32'h0140_0010);
        chk("ones.w7_hand", cap[7], 32'h0140_0010);

`ifdef POLY_FREEZE_EN
        fill_const(16'd0); mem[0] = 16'd12288;
        run("q_minus1", -1, -1, 1'b1);
        chk("q_minus1.w0_hand", cap[0], 32'h0030_0000);

        fill_const(16'd0); mem[0] = 16'd12289;
        run("q", -1, -1, 1'b1);
        chk("q.w0_hand", cap[0], 32'h0000_0000);

        fill_const(16'd0); mem[0] = 16'd61444;
        run("5q_minus1", -1, -1, 1'b1);
        chk("5q_minus1.w0_hand", cap[0], 32'h0030_0000);

        fill_const(16'd0); mem[0] = 16'd65535;
        run("max", -1, -1, 1'b1);
        chk("max.w0_hand", cap[0], 32'hFA0F_0000);
`else
        fill_const(16'd0); mem[0] = 16'd12289;
        run("q_trunc", -1, -1, 1'b1);
        chk("q_trunc.w0_hand", cap[0], 32'h0130_0000);
`endif

`ifdef POLY_FREEZE_EN
        fill_rand(5 * Q - 1);
`else
        fill_rand(Q - 1);
`endif
        run("abort", -1, 100, 1'b0);
        run("after_abort", -1, -1, 1'b1);

`ifdef POLY_FREEZE_EN
        fill_rand(5 * Q - 1);
`else
        fill_rand(Q - 1);
`endif
        run("repulse", 50, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
